// File: rtl/mux_nch_rr_if.sv
// Handshake/bus bundle for mux_nch_rr: NCH producer lanes in, one registered
// consumer lane out. The master side drives the lanes and downstream ready.
interface mux_nch_rr_if #(
  parameter int WIDTH = 2,
  parameter int NCH   = 4
);
  localparam int SELW = $clog2(NCH);

  logic                   mode;
  logic [SELW-1:0]        sel;
  logic [NCH*WIDTH-1:0]   data_in;
  logic [NCH-1:0]         valid_in;
  logic [NCH-1:0]         ready_out;
  logic                   ready_in;
  logic [WIDTH-1:0]       data_out;
  logic                   valid_out;
  logic [SELW-1:0]        ch_out;

  modport master (
    output mode, sel, data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out, ch_out
  );

  modport slave (
    input  mode, sel, data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out, ch_out
  );
endinterface

// File: rtl/mux_nch_rr.sv
// Registered N-channel multiplexer with valid/ready handshake.
// mode=0 picks the lane named by sel; mode=1 arbitrates round-robin from an
// internal pointer that advances past each granted lane (explicit wrap).
module mux_nch_rr #(
  parameter int WIDTH = 2,
  parameter int NCH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  mux_nch_rr_if.slave   bus
);
  localparam int SELW = $clog2(NCH);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             load_s;
  logic             gnt_vld_s;
  logic [SELW-1:0]  gnt_idx_s;
  logic             xfer_s;
  logic [NCH-1:0]   ready_s;
  int               cand_s;

  // The output register can take a word when empty or being drained this cycle.
  assign load_s = !valid_q || bus.ready_in;
  assign xfer_s = load_s && gnt_vld_s;

  // Grant selection: direct lookup of sel, or first valid lane scanning from ptr.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    cand_s    = 0;
    if (bus.mode == 1'b0) begin
      if (int'(bus.sel) < NCH) begin
        if (bus.valid_in[bus.sel]) begin
          gnt_vld_s = 1'b1;
          gnt_idx_s = bus.sel;
        end else begin
          gnt_vld_s = 1'b0;
        end
      end else begin
        gnt_vld_s = 1'b0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cand_s = int'(ptr_q) + i;
        if (cand_s >= NCH) begin
          cand_s = cand_s - NCH;
        end else begin
          cand_s = cand_s;
        end
        if (!gnt_vld_s && bus.valid_in[SELW'(cand_s)]) begin
          gnt_vld_s = 1'b1;
          gnt_idx_s = SELW'(cand_s);
        end else begin
          gnt_vld_s = gnt_vld_s;
        end
      end
    end
  end

  // One-hot ready back to the granted lane only; silent while in reset.
  always_comb begin
    ready_s = '0;
    if (gnt_vld_s && reset) begin
      ready_s[gnt_idx_s] = load_s;
    end else begin
      ready_s = '0;
    end
  end

  // Next-state for output register and arbitration pointer.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    if (xfer_s) begin
      data_d  = bus.data_in[int'(gnt_idx_s)*WIDTH +: WIDTH];
      ch_d    = gnt_idx_s;
      valid_d = 1'b1;
      if (bus.mode == 1'b1) begin
        if (gnt_idx_s == SELW'(NCH-1)) begin
          ptr_d = '0;
        end else begin
          ptr_d = gnt_idx_s + SELW'(1);
        end
      end else begin
        ptr_d = ptr_q;
      end
    end else if (load_s) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State registers; reset discards any held word and rewinds the pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.ready_out = ready_s;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.ch_out    = ch_q;
endmodule
